// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the direct-mapped instruction cache.
//   INDEX_W / ADDR_W : geometry (64 one-word lines, 18 significant address bits)
//   TAG_W            : tag width derived from the geometry
//   state_t          : controller states IDLE / MISS / DRAIN
//   split_addr()     : splits a word address into tag and line index
package icache_pkg;

    localparam int INDEX_W = 6;
    localparam int ADDR_W  = 18;
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;
    localparam int LINES   = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
    } addr_split_t;

    // Takes only the significant word-address bits so that callers pass
    // exactly what the cache looks at; byte-offset bits never reach here.
    function automatic addr_split_t split_addr(input logic [ADDR_W-1:2] word_addr);
        addr_split_t s;
        s.tag   = word_addr[ADDR_W-1:INDEX_W+2];
        s.index = word_addr[INDEX_W+1:2];
        return s;
    endfunction

endpackage

// File: rtl/icache_if_if.sv
// icache_if_if: fetch-side and memory-side signal bundle of the instruction cache.
//   Fetch side : req_i, addr_i, jump_i in; busy_o, valid_o, inst_o, pc_o out
//   Memory side: mem_req_o, mem_addr_o out; mem_valid_i, mem_data_i in
//   Directions are named from the cache's point of view.
//   slave  modport : used by the cache itself
//   master modport : used by whatever drives the cache (pc_if / memory / bench)
interface icache_if_if;

    logic        req_i;
    logic [31:0] addr_i;
    logic        jump_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;

    modport slave (
        input  req_i, addr_i, jump_i, mem_valid_i, mem_data_i,
        output busy_o, valid_o, inst_o, pc_o, mem_req_o, mem_addr_o
    );

    modport master (
        output req_i, addr_i, jump_i, mem_valid_i, mem_data_i,
        input  busy_o, valid_o, inst_o, pc_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped cache.
//   clk, rst        : clock, synchronous active-high reset (clears valid bits only)
//   we, windex      : synchronous line write enable and line index
//   wtag, wdata     : tag and instruction word written on a fill
//   rindex          : combinational lookup index
//   rvalid, rtag,
//   rdata           : contents of the looked-up line
module icache_array
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [INDEX_W-1:0] windex,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [31:0]        wdata,
    input  logic [INDEX_W-1:0] rindex,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag,
    output logic [31:0]        rdata
);

    logic [LINES-1:0] valid_bits;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    // Valid bits are a flat register so that reset empties the whole cache
    // in a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
        end else if (we) begin
            valid_bits[windex] <= 1'b1;
        end
    end

    // Tag and data are plain storage; stale contents are harmless because
    // the valid bit guards every lookup.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[windex] <= wtag;
            data[windex] <= wdata;
        end
    end

    assign rvalid = valid_bits[rindex];
    assign rtag   = tags[rindex];
    assign rdata  = data[rindex];

endmodule

// File: rtl/icache_if.sv
// icache_if: direct-mapped, one-word-per-line instruction cache for the IF stage.
//   clk, rst  : clock, synchronous active-high reset
//   rdy_i     : global ready; low freezes all state, array writes and outputs
//   bus       : icache_if_if.slave (fetch request/response and memory fetch port)
//   Hits deliver valid_o one cycle after the request; misses fetch a word
//   over mem_req_o/mem_addr_o and deliver it the cycle after mem_valid_i.
//   Optional macro ICACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters of
//   accepted requests.
module icache_if
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_i,
    icache_if_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    state_t      state, state_n;
    logic        valid_q, valid_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] mem_addr_q, mem_addr_n;
    logic [31:0] miss_pc_q, miss_pc_n;

    logic        fill_req;
    logic        accept_hit;
    logic        accept_miss;

    addr_split_t lookup;
    addr_split_t fill;
    logic        line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0] line_data;
    logic        hit;

    assign lookup = split_addr(bus.addr_i[ADDR_W-1:2]);
    assign fill   = split_addr(miss_pc_q[ADDR_W-1:2]);

    icache_array u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (fill_req & rdy_i & ~rst),
        .windex (fill.index),
        .wtag   (fill.tag),
        .wdata  (bus.mem_data_i),
        .rindex (lookup.index),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data)
    );

    assign hit = line_valid && (line_tag == lookup.tag);

    // State and output registers; everything holds while rdy_i is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
            mem_addr_q <= '0;
            miss_pc_q  <= '0;
        end else if (rdy_i) begin
            state      <= state_n;
            valid_q    <= valid_n;
            inst_q     <= inst_n;
            pc_q       <= pc_n;
            mem_addr_q <= mem_addr_n;
            miss_pc_q  <= miss_pc_n;
        end
    end

    // Next-state logic. valid_o is a pulse, so it defaults low; inst_o and
    // pc_o keep their last delivered values. A jump always kills the pending
    // delivery, but a fill already on mem_data_i is still written because
    // the memory controller cannot take it back.
    always_comb begin
        state_n     = state;
        valid_n     = 1'b0;
        inst_n      = inst_q;
        pc_n        = pc_q;
        mem_addr_n  = mem_addr_q;
        miss_pc_n   = miss_pc_q;
        fill_req    = 1'b0;
        accept_hit  = 1'b0;
        accept_miss = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_i && !bus.jump_i) begin
                    if (hit) begin
                        accept_hit = 1'b1;
                        valid_n    = 1'b1;
                        inst_n     = line_data;
                        pc_n       = bus.addr_i;
                    end else begin
                        accept_miss = 1'b1;
                        state_n     = MISS;
                        mem_addr_n  = {bus.addr_i[31:2], 2'b00};
                        miss_pc_n   = bus.addr_i;
                    end
                end
            end
            MISS: begin
                if (bus.mem_valid_i) begin
                    fill_req = 1'b1;
                    state_n  = IDLE;
                    if (!bus.jump_i) begin
                        valid_n = 1'b1;
                        inst_n  = bus.mem_data_i;
                        pc_n    = miss_pc_q;
                    end
                end else if (bus.jump_i) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_valid_i) begin
                    fill_req = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy_o     = (state != IDLE);
    assign bus.mem_req_o  = (state != IDLE);
    assign bus.valid_o    = valid_q;
    assign bus.inst_o     = inst_q;
    assign bus.pc_o       = pc_q;
    assign bus.mem_addr_o = mem_addr_q;

`ifdef ICACHE_STATS_EN
    // Accepted requests only exist in IDLE, so the FSM's accept strobes
    // already encode req_i & ~busy_o & ~jump_i; rdy_i gates the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (rdy_i) begin
            hit_cnt_o  <= hit_cnt_o + 32'(accept_hit);
            miss_cnt_o <= miss_cnt_o + 32'(accept_miss);
        end
    end
`endif

endmodule

// File: tb/tb_icache_if.sv
// tb_icache_if: self-checking bench for icache_if.
//   Line-level reference model (valid/tag/data per index), directed
//   sequences for the multi-cycle cases, a table of single-cycle IDLE
//   vectors and a randomized fetch loop. Define ICACHE_STATS_EN to also
//   compare the statistics counters.
module tb_icache_if;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    icache_if_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_if dut (
        .clk   (clk),
        .rst   (rst),
        .rdy_i (rdy),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per line.
    bit          m_valid [64];
    logic [9:0]  m_tag   [64];
    logic [31:0] m_data  [64];
    int          exp_hits;
    int          exp_misses;

    typedef struct {
        bit          req;
        bit          jump;
        logic [31:0] addr;
        bit          exp_valid;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h0000_0013;
        else if (a[31:16] == 16'h0)
            return 32'hC0DE_0000 | {16'h0, a[15:0]};
        else
            return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    function automatic logic [9:0] tag_of(input logic [31:0] a);
        return 10'((a >> 8) & 32'h3FF);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic apply_stimulus(input bit req, input bit jump, input logic [31:0] addr);
        bus.req_i  = req;
        bus.jump_i = jump;
        bus.addr_i = addr;
    endtask

    // One complete fetch. mode: 0 expect hit, 1 expect miss, 2 ask the model.
    // jump_at in [0,lat-1] pulses jump_i during the wait, jump_at == lat puts
    // it on the mem_valid_i cycle, -1 means no jump. stall_at >= 0 drops
    // rdy_i for stall_len cycles before wait cycle stall_at.
    task automatic do_fetch(input logic [31:0] addr, input int mode, input int lat,
                            input int jump_at, input int stall_at, input int stall_len);
        int          idx;
        bit          exp_hit;
        bit          jumped;
        logic [31:0] held_inst;
        logic [31:0] held_pc;
        idx     = line_of(addr);
        exp_hit = (mode == 2) ? (m_valid[idx] && m_tag[idx] == tag_of(addr)) : (mode == 0);
        apply_stimulus(1'b1, 1'b0, addr);
        bus.mem_valid_i = 1'b0;
        rdy = 1'b1;
        tick();
        if (exp_hit) begin
            exp_hits++;
            check_output("hit_valid", 32'(bus.valid_o), 32'd1);
            check_output("hit_inst", bus.inst_o, m_data[idx]);
            check_output("hit_pc", bus.pc_o, addr);
            check_output("hit_busy", 32'(bus.busy_o), 32'd0);
            check_output("hit_memreq", 32'(bus.mem_req_o), 32'd0);
            apply_stimulus(1'b0, 1'b0, addr);
            return;
        end
        exp_misses++;
        check_output("miss_valid", 32'(bus.valid_o), 32'd0);
        check_output("miss_busy", 32'(bus.busy_o), 32'd1);
        check_output("miss_memreq", 32'(bus.mem_req_o), 32'd1);
        check_output("miss_memaddr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
        jumped = 1'b0;
        for (int k = 0; k < lat; k++) begin
            if (k == stall_at) begin
                held_inst = bus.inst_o;
                held_pc   = bus.pc_o;
                rdy = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    apply_stimulus(1'b1, 1'($urandom_range(0, 1)), $urandom);
                    tick();
                    check_output("stall_busy", 32'(bus.busy_o), 32'd1);
                    check_output("stall_memreq", 32'(bus.mem_req_o), 32'd1);
                    check_output("stall_memaddr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
                    check_output("stall_valid", 32'(bus.valid_o), 32'd0);
                    check_output("stall_inst", bus.inst_o, held_inst);
                    check_output("stall_pc", bus.pc_o, held_pc);
                end
                rdy = 1'b1;
            end
            apply_stimulus(1'b1, (k == jump_at), addr);
            if (k == jump_at) jumped = 1'b1;
            tick();
            check_output("wait_busy", 32'(bus.busy_o), 32'd1);
            check_output("wait_memreq", 32'(bus.mem_req_o), 32'd1);
            check_output("wait_valid", 32'(bus.valid_o), 32'd0);
        end
        apply_stimulus(1'b0, (jump_at == lat), addr);
        if (jump_at == lat) jumped = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = mem_word(addr);
        tick();
        bus.mem_valid_i = 1'b0;
        bus.jump_i      = 1'b0;
        check_output("fill_valid", 32'(bus.valid_o), jumped ? 32'd0 : 32'd1);
        if (!jumped) begin
            check_output("fill_inst", bus.inst_o, mem_word(addr));
            check_output("fill_pc", bus.pc_o, addr);
        end
        check_output("fill_busy", 32'(bus.busy_o), 32'd0);
        check_output("fill_memreq", 32'(bus.mem_req_o), 32'd0);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag_of(addr);
        m_data[idx]  = mem_word(addr);
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_busy"}, 32'(bus.busy_o), 32'd0);
        check_output({name, "_valid"}, 32'(bus.valid_o), 32'd0);
        check_output({name, "_inst"}, bus.inst_o, 32'd0);
        check_output({name, "_pc"}, bus.pc_o, 32'd0);
        check_output({name, "_memreq"}, 32'(bus.mem_req_o), 32'd0);
        check_output({name, "_memaddr"}, bus.mem_addr_o, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          lat;
        int          jat;
        int          sat;

        rdy = 1'b1;
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = 32'h0;
        model_reset();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Cold miss, then hit on the same PC.
        do_fetch(32'h0000_0000, 1, 5, -1, -1, 0);
        do_fetch(32'h0000_0000, 0, 1, -1, -1, 0);

        // Conflict eviction on index 1.
        do_fetch(32'h0000_0004, 1, 2, -1, -1, 0);
        do_fetch(32'h0000_0104, 1, 2, -1, -1, 0);
        do_fetch(32'h0000_0004, 1, 2, -1, -1, 0);

        // Jump mid-miss: no delivery but the line still fills.
        do_fetch(32'h0000_0008, 1, 4, 2, -1, 0);
        do_fetch(32'h0000_0008, 0, 1, -1, -1, 0);

        // Global stall during a miss.
        do_fetch(32'h0000_0010, 1, 4, -1, 1, 3);

        // Single-cycle IDLE vectors over the lines filled above.
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'hC0DE_0004};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'hC0DE_0008};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'hC0DE_0010};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0013};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].req, vecs[i].jump, vecs[i].addr);
            tick();
            if (vecs[i].req && !vecs[i].jump) exp_hits++;
            check_output($sformatf("vec%0d_valid", i), 32'(bus.valid_o), 32'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d_busy", i), 32'(bus.busy_o), 32'd0);
            check_output($sformatf("vec%0d_memreq", i), 32'(bus.mem_req_o), 32'd0);
            if (vecs[i].exp_valid) begin
                check_output($sformatf("vec%0d_inst", i), bus.inst_o, vecs[i].exp_inst);
                check_output($sformatf("vec%0d_pc", i), bus.pc_o, vecs[i].addr);
            end
        end
        apply_stimulus(1'b0, 1'b0, 32'h0);

        // Randomized fetch stream over a few indices and tags, with
        // occasional aliasing upper bits, jumps and stalls.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                apply_stimulus(1'b1, 1'b1, $urandom & 32'hFFFF_FFFC);
                tick();
                check_output("rnd_idlejump_valid", 32'(bus.valid_o), 32'd0);
                check_output("rnd_idlejump_busy", 32'(bus.busy_o), 32'd0);
                apply_stimulus(1'b0, 1'b0, 32'h0);
            end else begin
                a = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFC_0000) : 32'h0)
                    | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
                lat = $urandom_range(1, 6);
                jat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
                sat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat - 1) : -1;
                do_fetch(a, 2, lat, jat, sat, $urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    check_output("rnd_pulse_end", 32'(bus.valid_o), 32'd0);
                end
            end
        end

`ifdef ICACHE_STATS_EN
        check_output("hit_cnt", hit_cnt, 32'(exp_hits));
        check_output("miss_cnt", miss_cnt, 32'(exp_misses));
`endif

        // Reset in the middle of a miss empties the cache.
        apply_stimulus(1'b1, 1'b0, 32'h0000_03FC);
        tick();
        check_output("rstmiss_busy", 32'(bus.busy_o), 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_reset_outputs("rstmiss");
        do_fetch(32'h0000_0000, 1, 2, -1, -1, 0);

`ifdef ICACHE_STATS_EN
        check_output("hit_cnt_after_rst", hit_cnt, 32'(exp_hits));
        check_output("miss_cnt_after_rst", miss_cnt, 32'(exp_misses));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_if.md
Name: icache_if

Overview:
- Direct-mapped instruction cache between the fetch-PC stage and the memory controller's fetch port.
- Returns hits in one cycle. On a miss, fetches one 32-bit word from the memory controller, then fills the line and returns the word.
- Produces the pc/instruction pair that the IF/ID pipeline register latches, using the same busy-low-means-valid convention as the fetch path.

Parameters:
- INDEX_W, 6, index width; the cache holds 2^INDEX_W one-word lines (64).
- ADDR_W, 18, significant address bits; only mem_a[17:0] is used.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy_i  in  1  global ready; when low, all state and outputs freeze
- req_i  in  1  fetch request from pc_if
- addr_i  in  32  fetch PC, word aligned
- jump_i  in  1  redirect/flush from ID; the current fetch is discarded
- busy_o  out  1  high while a fetch is outstanding; low with valid_o means inst_o is valid
- valid_o  out  1  one-cycle pulse: inst_o/pc_o hold a delivered instruction
- inst_o  out  32  instruction word
- pc_o  out  32  PC of inst_o
- mem_req_o  out  1  miss request to the memory controller fetch port
- mem_addr_o  out  32  miss word address
- mem_valid_i  in  1  one-cycle pulse: the memory controller has the assembled word
- mem_data_i  in  32  word from the memory controller, valid with mem_valid_i

Behaviour:
- Address split: tag = addr_i[ADDR_W-1:INDEX_W+2]; index = addr_i[INDEX_W+1:2]; bits [1:0] are ignored.
- Storage: valid bit, tag and data per line. On reset, all valid bits clear in one cycle. Tag and data arrays are not reset.
- Reset values: busy_o=0, valid_o=0, inst_o=0, pc_o=0, mem_req_o=0, mem_addr_o=0, state=IDLE.
- State machine, states IDLE, MISS, DRAIN:
  - IDLE, req_i=1, jump_i=0, hit: next cycle valid_o=1 with inst_o=line data and pc_o=addr_i; busy_o stays 0. Hit latency is 1 cycle, back-to-back throughput is 1 per cycle.
  - IDLE, req_i=1, jump_i=0, miss: go to MISS. mem_req_o=1 and mem_addr_o={addr_i[31:2],2'b00} from the next cycle. busy_o=1. The PC is latched.
  - MISS, mem_valid_i=1: write the line (valid=1, tag, data). Next cycle valid_o=1, inst_o=mem_data_i, pc_o=latched PC. mem_req_o drops, busy_o drops, go to IDLE.
  - MISS, jump_i=1: go to DRAIN. mem_req_o stays high, because the controller cannot abort a byte sequence.
  - DRAIN, mem_valid_i=1: fill the line, suppress valid_o, go to IDLE. busy_o stays 1 throughout DRAIN.
- jump_i in IDLE: any valid_o scheduled for the next cycle is suppressed. req_i in the same cycle is ignored.
- jump_i together with mem_valid_i in MISS: fill the line, suppress the output, go to IDLE.
- Only one outstanding miss at a time. req_i is ignored while busy_o=1; pc_if must hold its request.
- rdy_i=0 freezes everything, including array writes, and holds outputs. A mem_valid_i pulse arriving while rdy_i=0 is not guaranteed to be captured; the memory controller is frozen under rdy_i as well.
- rst in any state, including mid-miss, returns to IDLE within one cycle with all outputs at their reset values.
- Stores do not invalidate lines. Self-modifying code is unsupported.
- An address with the same index but a different tag evicts the existing line on fill.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Each counts accepted requests (req_i & ~busy_o & ~jump_i & rdy_i) classified as hit or miss.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg: state encoding (IDLE=2'd0, MISS=2'd1, DRAIN=2'd2), derived TAG_W = ADDR_W-INDEX_W-2, and an address-split helper.
- One natural sub-module, icache_array: the tag/valid/data storage with a synchronous write port and a combinational read port. The FSM stays in icache_if.

Test Plan:
- Cold miss: req addr 0x00000000 with empty cache -> mem_req_o=1, mem_addr_o=0x0. Memory returns 0x00000013 after 5 cycles -> valid_o pulse with inst_o=0x00000013, pc_o=0x0.
- Hit: repeat addr 0x0 -> valid_o on the next cycle, inst_o=0x00000013, no mem_req_o.
- Conflict eviction with INDEX_W=6: fill 0x004, then 0x104 (same index) -> a miss each time. Re-request 0x004 -> miss again.
- Jump mid-miss: miss on 0x008, jump_i at cycle 2 -> no valid_o; state DRAIN until mem_valid_i; the line is filled, so a later req 0x008 hits.
- rdy_i low for 3 cycles during MISS -> outputs held, no state change. The miss completes normally after rdy_i returns high.
- Reset mid-miss -> IDLE, busy_o=0, mem_req_o=0; a subsequent req 0x0 misses because valid bits were cleared.
